// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: colour constants, encoder bit timing and the
// frame sequencer state encoding.
package ws2812_pkg;

  localparam logic [23:0] OFF   = 24'h000000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  // Encoder timing in clock cycles; each bit period totals 1100 cycles.
  localparam int unsigned T0H = 32'd350;
  localparam int unsigned T0L = 32'd750;
  localparam int unsigned T1H = 32'd700;
  localparam int unsigned T1L = 32'd400;
  localparam int unsigned RST = 32'd15000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    return (value >= max) ? max : value + 32'd1;
  endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Pixel colour store: one write port, one registered read port, write-first on
// a same-address collision. Contents and read register are not reset.
module ws2812_pixel_ram #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       rd_data
);

  logic [23:0] mem [1<<ADDR_W];

  // Storage write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; a simultaneous write to the same address is forwarded.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Streams the pixel RAM to the WS2812 encoder one LED at a time, then waits out
// the latch gap before pulsing frame_done. Frames start on request or refresh.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS       = 8,
  parameter int ADDR_W         = 3,
  parameter int RESET_CYCLES   = 42000,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  input  logic              auto_refresh,
  output logic              pix_valid,
  output logic [23:0]       pix_data,
  output logic              pix_last,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_LEDS - 1);
  localparam logic [31:0]       LATCH_MAX   = 32'(RESET_CYCLES - 1);
  localparam logic [31:0]       REFRESH_MAX = 32'(REFRESH_CYCLES - 1);

  state_t            state, state_nxt;
  logic              pending, pending_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [31:0]       latch_cnt, latch_nxt;
  logic [31:0]       refresh_cnt, refresh_nxt;
  logic              pix_valid_nxt, pix_last_nxt, busy_nxt, frame_done_nxt;
  logic              rd_en;
  logic              req;
  logic              go;
  logic [23:0]       ram_data;

  ws2812_pixel_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (idx),
    .rd_data (ram_data)
  );

  // The read register only loads in FETCH, so it is stable for the whole SEND.
  assign pix_data = pix_valid ? ram_data : OFF;

  assign req = start | (auto_refresh & (refresh_cnt == REFRESH_MAX));
  assign go  = pending | req;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      idx         <= '0;
      latch_cnt   <= 32'd0;
      refresh_cnt <= 32'd0;
      pix_valid   <= 1'b0;
      pix_last    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      idx         <= idx_nxt;
      latch_cnt   <= latch_nxt;
      refresh_cnt <= refresh_nxt;
      pix_valid   <= pix_valid_nxt;
      pix_last    <= pix_last_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    pending_nxt    = pending | req;
    idx_nxt        = idx;
    latch_nxt      = latch_cnt;
    refresh_nxt    = sat_inc(refresh_cnt, REFRESH_MAX);
    pix_valid_nxt  = 1'b0;
    pix_last_nxt   = pix_last;
    frame_done_nxt = 1'b0;
    rd_en          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt   = ST_FETCH;
          pending_nxt = 1'b0;
          idx_nxt     = '0;
          refresh_nxt = 32'd0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        rd_en         = 1'b1;
        state_nxt     = ST_SEND;
        pix_valid_nxt = 1'b1;
        pix_last_nxt  = (idx == LAST_IDX);
      end
      ST_SEND: begin
        if (pix_ready) begin
          pix_last_nxt = 1'b0;
          if (idx == LAST_IDX) begin
            state_nxt = ST_LATCH;
            latch_nxt = 32'd0;
          end else begin
            state_nxt = ST_FETCH;
            idx_nxt   = idx + ADDR_W'(1);
          end
        end else begin
          pix_valid_nxt = 1'b1;
        end
      end
      ST_LATCH: begin
        if (latch_cnt == LATCH_MAX) begin
          frame_done_nxt = 1'b1;
          if (go) begin
            // Back-to-back frame: restart without passing through IDLE.
            state_nxt   = ST_FETCH;
            pending_nxt = 1'b0;
            idx_nxt     = '0;
            refresh_nxt = 32'd0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          latch_nxt = latch_cnt + 32'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer: expected pixels are queued as
// frames are requested and compared as the encoder handshake accepts them.
module tb_ws2812_frame_sequencer;

  localparam int NUM_LEDS       = 4;
  localparam int ADDR_W         = 3;
  localparam int RESET_CYCLES   = 100;
  localparam int REFRESH_CYCLES = 600;
  localparam int FRAME_BUSY     = 2 * NUM_LEDS + RESET_CYCLES;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              start;
  logic              auto_refresh;
  logic              pix_valid;
  logic [23:0]       pix_data;
  logic              pix_last;
  logic              pix_ready;
  logic              busy;
  logic              frame_done;

  always #5 clk = ~clk;

  ws2812_frame_sequencer #(
    .NUM_LEDS       (NUM_LEDS),
    .ADDR_W         (ADDR_W),
    .RESET_CYCLES   (RESET_CYCLES),
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .auto_refresh (auto_refresh),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_last     (pix_last),
    .pix_ready    (pix_ready),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  int          cyc     = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_cycles = 0;
  logic        busy_prev = 1'b0;
  logic [24:0] exp_q[$];
  int          xfer_cyc_q[$];
  int          rise_q[$];
  logic [23:0] led [NUM_LEDS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic sample();
    logic [24:0] e;
    if (pix_valid && pix_ready) begin
      xfer_cyc_q.push_back(cyc);
      check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix_data", 32'(pix_data), 32'(e[23:0]));
        check("pix_last", 32'(pix_last), 32'(e[24]));
      end
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cycles++;
    if (busy && !busy_prev) rise_q.push_back(cyc);
    busy_prev = busy;
  endtask

  // One clock: sample outputs on the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NUM_LEDS; i++) exp_q.push_back({(i == NUM_LEDS - 1), led[i]});
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check("frame_done_seen", 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!pix_valid && n < budget) begin
      tick();
      n++;
    end
    check("pix_valid_seen", 32'(pix_valid), 32'd1);
  endtask

  task automatic pulse_start(output int sc);
    sc = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int sc, d1, d_base, unstable, a;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 24'h0;
    start = 1'b0; auto_refresh = 1'b0; pix_ready = 1'b1;
    led[0] = 24'h110000; led[1] = 24'h002200; led[2] = 24'h000033; led[3] = 24'hFFFFFF;
    repeat (3) tick();
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_pix_last", 32'(pix_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < NUM_LEDS; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = led[i];
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Basic frame, ready always high.
    xfer_cyc_q.delete();
    push_frame();
    pulse_start(sc);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(400);
    check("t1_xfer_count", 32'(xfer_cyc_q.size()), 32'd4);
    check("t1_first_latency", 32'(xfer_cyc_q[0]), 32'(sc + 2));
    check("t1_second_xfer", 32'(xfer_cyc_q[1]), 32'(sc + 4));
    check("t1_last_xfer", 32'(xfer_cyc_q[3]), 32'(sc + 8));
    check("t1_done_cycle", 32'(done_cyc), 32'(sc + 8 + RESET_CYCLES + 1));
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_done_pulse", 32'(frame_done), 32'd0);

    // Encoder stall for 50 cycles.
    pix_ready = 1'b0;
    xfer_cyc_q.delete();
    push_frame();
    pulse_start(sc);
    wait_valid(10);
    unstable = 0;
    repeat (50) begin
      tick();
      if (pix_valid !== 1'b1 || pix_data !== led[0] || pix_last !== 1'b0) unstable++;
    end
    check("t2_stable", 32'(unstable), 32'd0);
    check("t2_no_xfer", 32'(xfer_cyc_q.size()), 32'd0);
    pix_ready = 1'b1;
    tick();
    check("t2_one_xfer", 32'(xfer_cyc_q.size()), 32'd1);
    wait_done(400);
    check("t2_xfer_count", 32'(xfer_cyc_q.size()), 32'd4);

    // Three requests during a frame collapse into one follow-up frame.
    xfer_cyc_q.delete();
    d_base = done_cnt;
    push_frame();
    push_frame();
    pulse_start(sc);
    repeat (2) tick();
    pulse_start(sc);
    repeat (3) tick();
    pulse_start(sc);
    repeat (30) tick();
    wait_done(400);
    d1 = done_cyc;
    check("t3_busy_continues", 32'(busy), 32'd1);
    wait_done(400);
    check("t3_xfer_count", 32'(xfer_cyc_q.size()), 32'd8);
    check("t3_restart_cycle", 32'(xfer_cyc_q[4]), 32'(d1 + 1));
    repeat (300) tick();
    check("t3_frame_count", 32'(done_cnt - d_base), 32'd2);
    check("t3_idle", 32'(busy), 32'd0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Writes ahead of the fetch pointer, including a same-cycle write during FETCH.
    led[2] = 24'hABCDEF;
    push_frame();
    pulse_start(sc);
    repeat (3) tick();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'hABCDEF;
    tick();
    wr_en = 1'b0;
    wait_done(400);
    led[2] = 24'h123456;
    push_frame();
    pulse_start(sc);
    repeat (4) tick();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'h123456;
    tick();
    wr_en = 1'b0;
    wait_done(400);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Auto-refresh: three frames spaced by the refresh period.
    repeat (700) tick();
    rise_q.delete();
    busy_cycles = 0;
    push_frame(); push_frame(); push_frame();
    a = cyc;
    auto_refresh = 1'b1;
    repeat (1500) tick();
    auto_refresh = 1'b0;
    check("t4_frames", 32'(rise_q.size()), 32'd3);
    check("t4_first_rise", 32'(rise_q[0]), 32'(a + 1));
    check("t4_period1", 32'(rise_q[1] - rise_q[0]), 32'(REFRESH_CYCLES));
    check("t4_period2", 32'(rise_q[2] - rise_q[1]), 32'(REFRESH_CYCLES));
    check("t4_busy_cycles", 32'(busy_cycles), 32'(3 * FRAME_BUSY));
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of SEND.
    pix_ready = 1'b0;
    pulse_start(sc);
    wait_valid(10);
    rst = 1'b0;
    #1;
    check("t6_valid_drop", 32'(pix_valid), 32'd0);
    check("t6_busy_drop", 32'(busy), 32'd0);
    check("t6_data_zero", 32'(pix_data), 32'd0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("t6_still_idle", 32'(busy), 32'd0);
    pix_ready = 1'b1;
    xfer_cyc_q.delete();
    push_frame();
    pulse_start(sc);
    wait_done(400);
    check("t6_replay_count", 32'(xfer_cyc_q.size()), 32'd4);
    check("t6_replay_latency", 32'(xfer_cyc_q[0]), 32'(sc + 2));
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
